// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller for the AXI-Lite configured 8-bit LFSR stream generator:
// writes seed, taps and start, counts observed stream beats, then writes stop and stop-clear.
module lfsr_seq_ctrl #(
   parameter int C_AXIL_ADDR_WIDTH = 4,
   parameter int C_AXIL_DATA_WIDTH = 32,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [7:0]                   cmd_seed,
   input  logic [7:0]                   cmd_taps,
   input  logic [CNT_WIDTH-1:0]         cmd_count,
   input  logic                         abort,
   output logic [C_AXIL_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                         m_axi_awvalid,
   input  logic                         m_axi_awready,
   output logic [C_AXIL_DATA_WIDTH-1:0] m_axi_wdata,
   output logic                         m_axi_wvalid,
   input  logic                         m_axi_wready,
   input  logic [1:0]                   m_axi_bresp,
   input  logic                         m_axi_bvalid,
   output logic                         m_axi_bready,
   input  logic                         mon_tvalid,
   input  logic                         mon_tready,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [CNT_WIDTH-1:0]         beats_seen
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WR_SEED  = 3'd1,
      S_WR_TAPS  = 3'd2,
      S_WR_START = 3'd3,
      S_RUN      = 3'd4,
      S_WR_STOP  = 3'd5,
      S_WR_CLR   = 3'd6,
      S_DONE     = 3'd7
   } state_t;

   localparam logic [C_AXIL_ADDR_WIDTH-1:0] ADDR_CTRL = C_AXIL_ADDR_WIDTH'(4'h0);
   localparam logic [C_AXIL_ADDR_WIDTH-1:0] ADDR_STOP = C_AXIL_ADDR_WIDTH'(4'h4);
   localparam logic [C_AXIL_ADDR_WIDTH-1:0] ADDR_SEED = C_AXIL_ADDR_WIDTH'(4'h8);
   localparam logic [C_AXIL_ADDR_WIDTH-1:0] ADDR_TAPS = C_AXIL_ADDR_WIDTH'(4'hC);
   localparam logic [C_AXIL_DATA_WIDTH-1:0] DATA_ONE  = C_AXIL_DATA_WIDTH'(1'b1);
   localparam logic [C_AXIL_DATA_WIDTH-1:0] DATA_ZERO = C_AXIL_DATA_WIDTH'(1'b0);

   state_t                         r_state;
   logic [7:0]                     r_taps;
   logic [CNT_WIDTH-1:0]           r_count;
   logic [CNT_WIDTH-1:0]           r_beats;
   logic [C_AXIL_ADDR_WIDTH-1:0]   r_awaddr;
   logic [C_AXIL_DATA_WIDTH-1:0]   r_wdata;
   logic                           r_awvalid;
   logic                           r_wvalid;
   logic                           r_bready;
   logic                           r_done;
   logic                           r_err;

   logic                           w_b_hs;
   logic                           w_beat;
   logic [CNT_WIDTH-1:0]           w_beats_inc;
   logic                           w_last_beat;

   assign w_b_hs      = r_bready & m_axi_bvalid;
   assign w_beat      = mon_tvalid & mon_tready;
   assign w_beats_inc = r_beats + CNT_WIDTH'(1'b1);
   assign w_last_beat = w_beat & (w_beats_inc == r_count);

   // Sequencer FSM with all AXI-Lite master and status outputs registered.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state   <= S_IDLE;
         r_taps    <= 8'h00;
         r_count   <= {CNT_WIDTH{1'b0}};
         r_beats   <= {CNT_WIDTH{1'b0}};
         r_awaddr  <= {C_AXIL_ADDR_WIDTH{1'b0}};
         r_wdata   <= {C_AXIL_DATA_WIDTH{1'b0}};
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // Each channel's valid drops on its own handshake; a new write below re-raises both.
         if (r_awvalid && m_axi_awready) begin
            r_awvalid <= 1'b0;
         end
         if (r_wvalid && m_axi_wready) begin
            r_wvalid <= 1'b0;
         end
         if (w_b_hs && (m_axi_bresp != 2'b00)) begin
            r_err <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_taps    <= cmd_taps;
                  r_count   <= cmd_count;
                  r_beats   <= {CNT_WIDTH{1'b0}};
                  r_state   <= S_WR_SEED;
                  r_awaddr  <= ADDR_SEED;
                  r_wdata   <= C_AXIL_DATA_WIDTH'(cmd_seed);
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_bready  <= 1'b1;
               end
            end
            S_WR_SEED: begin
               if (w_b_hs) begin
                  r_state   <= S_WR_TAPS;
                  r_awaddr  <= ADDR_TAPS;
                  r_wdata   <= C_AXIL_DATA_WIDTH'(r_taps);
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
               end
            end
            S_WR_TAPS: begin
               if (w_b_hs) begin
                  r_state   <= S_WR_START;
                  r_awaddr  <= ADDR_CTRL;
                  r_wdata   <= DATA_ONE;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
               end
            end
            S_WR_START: begin
               if (w_b_hs) begin
                  // A zero-length run goes straight to the stop write.
                  if (r_count == {CNT_WIDTH{1'b0}}) begin
                     r_state   <= S_WR_STOP;
                     r_awaddr  <= ADDR_STOP;
                     r_wdata   <= DATA_ONE;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                  end else begin
                     r_state  <= S_RUN;
                     r_bready <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (w_beat) begin
                  r_beats <= w_beats_inc;
               end
               if (w_last_beat || abort) begin
                  r_state   <= S_WR_STOP;
                  r_awaddr  <= ADDR_STOP;
                  r_wdata   <= DATA_ONE;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_bready  <= 1'b1;
               end
            end
            S_WR_STOP: begin
               if (w_b_hs) begin
                  r_state   <= S_WR_CLR;
                  r_awaddr  <= ADDR_STOP;
                  r_wdata   <= DATA_ZERO;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
               end
            end
            S_WR_CLR: begin
               if (w_b_hs) begin
                  r_state  <= S_DONE;
                  r_bready <= 1'b0;
                  r_done   <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state   <= S_IDLE;
               r_awvalid <= 1'b0;
               r_wvalid  <= 1'b0;
               r_bready  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready     = (r_state == S_IDLE);
   assign busy          = (r_state != S_IDLE);
   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign done          = r_done;
   assign err           = r_err;
   assign beats_seen    = r_beats;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: AXI-Lite slave model with programmable delays,
// write scoreboard, and a beat-count model built from observed handshakes.
module tb_lfsr_seq_ctrl;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int CW = 16;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          cmd_valid, cmd_ready;
   logic [7:0]    cmd_seed, cmd_taps;
   logic [CW-1:0] cmd_count;
   logic          abort;
   logic [AW-1:0] m_axi_awaddr;
   logic          m_axi_awvalid, m_axi_awready = 1'b0;
   logic [DW-1:0] m_axi_wdata;
   logic          m_axi_wvalid, m_axi_wready = 1'b0;
   logic [1:0]    m_axi_bresp = 2'b00;
   logic          m_axi_bvalid = 1'b0, m_axi_bready;
   logic          mon_tvalid, mon_tready = 1'b1;
   logic          busy, done, err;
   logic [CW-1:0] beats_seen;

   int n_tests = 0;
   int n_fail  = 0;
   logic [AW+DW-1:0] sb_q[$];

   int aw_dly = 0, w_dly = 0, b_dly = 0, err_wr = 0, tready_mode = 0;
   int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   bit aw_got = 0, w_got = 0;
   logic [AW-1:0] got_addr;
   logic [DW-1:0] got_data;
   int wr_num = 0, cur_count = 0, model_beats = 0;
   bit model_in_run = 0, exp_done = 0, exp_stop = 0, exp_err = 0;
   logic prev_awvalid = 1'b0, prev_awready = 1'b0, prev_wvalid = 1'b0, prev_wready = 1'b0;
   logic [AW-1:0] prev_awaddr;
   logic [DW-1:0] prev_wdata;

   always #5 aclk = ~aclk;

   lfsr_seq_ctrl #(.C_AXIL_ADDR_WIDTH(AW), .C_AXIL_DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seed(cmd_seed),
      .cmd_taps(cmd_taps), .cmd_count(cmd_count), .abort(abort),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
      .busy(busy), .done(done), .err(err), .beats_seen(beats_seen)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Edge-side model: handshake capture, scoreboard compare, beat counting.
   always @(posedge aclk) begin
      if (!aresetn) begin
         aw_got = 0; w_got = 0; wr_num = 0; model_beats = 0; model_in_run = 0;
         exp_done = 0; exp_stop = 0; exp_err = 0; prev_awvalid = 1'b0; prev_wvalid = 1'b0;
         sb_q.delete();
      end else begin
         if (prev_awvalid && !prev_awready)
            chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, prev_awaddr});
         if (prev_wvalid && !prev_wready)
            chk("w_hold", {m_axi_wvalid, m_axi_wdata}, {1'b1, prev_wdata});
         prev_awvalid = m_axi_awvalid; prev_awready = m_axi_awready; prev_awaddr = m_axi_awaddr;
         prev_wvalid = m_axi_wvalid; prev_wready = m_axi_wready; prev_wdata = m_axi_wdata;
         if (cmd_valid && cmd_ready) begin
            wr_num = 0; model_beats = 0; model_in_run = 0;
         end
         exp_done = 0; exp_stop = 0;
         if (model_in_run && mon_tvalid && mon_tready) begin
            model_beats++;
            if (model_beats == cur_count) begin model_in_run = 0; exp_stop = 1; end
         end
         if (model_in_run && abort) begin model_in_run = 0; exp_stop = 1; end
         if (m_axi_awvalid && m_axi_awready) begin
            chk("aw_once", {63'd0, aw_got}, 64'd0);
            aw_got = 1; got_addr = m_axi_awaddr;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            chk("w_once", {63'd0, w_got}, 64'd0);
            w_got = 1; got_data = m_axi_wdata;
         end
         if (m_axi_bvalid && m_axi_bready) begin
            wr_num++;
            if (m_axi_bresp != 2'b00) exp_err = 1;
            chk("sb_nonempty", {63'd0, sb_q.size() > 0}, 64'd1);
            if (sb_q.size() > 0) chk("wr_addr_data", {got_addr, got_data}, sb_q.pop_front());
            aw_got = 0; w_got = 0;
            if (wr_num == 3 && cur_count != 0) model_in_run = 1;
            if (wr_num == 5) exp_done = 1;
         end
      end
   end

   // Opposite-edge side: drive slave responses and check per-cycle outputs.
   always @(negedge aclk) begin
      if (m_axi_awvalid && !aw_got) begin
         if (aw_cnt >= aw_dly) m_axi_awready = 1'b1;
         else begin m_axi_awready = 1'b0; aw_cnt++; end
      end else begin m_axi_awready = 1'b0; aw_cnt = 0; end
      if (m_axi_wvalid && !w_got) begin
         if (w_cnt >= w_dly) m_axi_wready = 1'b1;
         else begin m_axi_wready = 1'b0; w_cnt++; end
      end else begin m_axi_wready = 1'b0; w_cnt = 0; end
      if (aw_got && w_got) begin
         if (b_cnt >= b_dly) m_axi_bvalid = 1'b1;
         else begin m_axi_bvalid = 1'b0; b_cnt++; end
      end else begin m_axi_bvalid = 1'b0; b_cnt = 0; end
      m_axi_bresp = (m_axi_bvalid && (wr_num + 1 == err_wr)) ? 2'b10 : 2'b00;
      mon_tready = (tready_mode == 0) ? 1'b1 : ~mon_tready;
      if (aresetn) begin
         chk("done", {63'd0, done}, {63'd0, exp_done});
         chk("beats_seen", {48'd0, beats_seen}, 64'(model_beats));
         chk("err", {63'd0, err}, {63'd0, exp_err});
         if (exp_stop) chk("run_exit", {m_axi_awvalid, m_axi_awaddr}, {1'b1, 4'h4});
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk(tag, {cmd_ready, busy, done, err, beats_seen, m_axi_awvalid, m_axi_wvalid,
                m_axi_bready, m_axi_awaddr, m_axi_wdata},
               {1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0});
   endtask

   task automatic run_cmd(input logic [7:0] s, input logic [7:0] t, input logic [CW-1:0] c);
      int k = 0;
      while (cmd_ready !== 1'b1 && k < 50) begin @(negedge aclk); k++; end
      chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
      cmd_seed = s; cmd_taps = t; cmd_count = c; cur_count = int'(c); cmd_valid = 1'b1;
      sb_q.push_back({4'h8, 24'd0, s});
      sb_q.push_back({4'hC, 24'd0, t});
      sb_q.push_back({4'h0, 32'd1});
      sb_q.push_back({4'h4, 32'd1});
      sb_q.push_back({4'h4, 32'd0});
      @(negedge aclk);
      cmd_valid = 1'b0;
      chk("first_write", {m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, busy, cmd_ready},
                         {1'b1, 1'b1, 4'h8, 1'b1, 1'b0});
   endtask

   task automatic wait_done(input int max_cyc);
      int k = 0;
      while (done !== 1'b1 && k < max_cyc) begin @(negedge aclk); k++; end
      chk("done_seen", {63'd0, done}, 64'd1);
      @(negedge aclk);
      chk("cmd_ready_after_done", {cmd_ready, done}, {1'b1, 1'b0});
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int k;
      aresetn = 1'b0; cmd_valid = 1'b0; cmd_seed = 8'h00; cmd_taps = 8'h00;
      cmd_count = 16'd0; abort = 1'b0; mon_tvalid = 1'b1;
      repeat (3) @(negedge aclk);
      chk_reset_vals("reset_vals");
      aresetn = 1'b1;

      run_cmd(8'h01, 8'hB4, 16'd5);
      wait_done(200);
      chk("basic_beats", {48'd0, beats_seen}, 64'd5);
      chk("basic_err", {63'd0, err}, 64'd0);

      aw_dly = 3; w_dly = 1; b_dly = 4;
      run_cmd(8'h5A, 8'h8E, 16'd3);
      wait_done(400);
      chk("bp_beats", {48'd0, beats_seen}, 64'd3);
      aw_dly = 0; w_dly = 0; b_dly = 0;

      tready_mode = 1;
      run_cmd(8'hC3, 8'h1D, 16'd4);
      wait_done(200);
      chk("gap_beats", {48'd0, beats_seen}, 64'd4);
      tready_mode = 0;

      abort = 1'b1;
      run_cmd(8'h77, 8'h99, 16'd0);
      wait_done(200);
      chk("zero_beats", {48'd0, beats_seen}, 64'd0);
      abort = 1'b0;

      run_cmd(8'h11, 8'h22, 16'd100);
      k = 0;
      while (model_beats != 10 && k < 100) begin @(negedge aclk); k++; end
      chk("abort_reach10", 64'(model_beats), 64'd10);
      abort = 1'b1;
      @(negedge aclk);
      abort = 1'b0;
      wait_done(200);
      chk("abort_beats", {48'd0, beats_seen}, 64'd11);

      err_wr = 2;
      run_cmd(8'hAA, 8'h55, 16'd3);
      wait_done(200);
      chk("err_set", {63'd0, err}, 64'd1);
      err_wr = 0;
      run_cmd(8'h0F, 8'hF0, 16'd20);
      chk("err_persist", {63'd0, err}, 64'd1);
      k = 0;
      while (model_beats < 3 && k < 100) begin @(negedge aclk); k++; end
      chk("reach_run", {63'd0, model_beats >= 3}, 64'd1);
      aresetn = 1'b0;
      @(negedge aclk);
      chk_reset_vals("midrun_reset");
      aresetn = 1'b1;
      @(negedge aclk);

      run_cmd(8'h01, 8'hB4, 16'd2);
      wait_done(200);
      chk("recover_beats", {48'd0, beats_seen}, 64'd2);
      chk("recover_err", {63'd0, err}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
